// File: rtl/alu_share_ctrl_if.sv
// Bundle of requester, Alu and response signals around alu_share_ctrl.
// The stat_grant* counters exist only when ALU_SHARE_STATS_EN is defined.
interface alu_share_ctrl_if #(
  parameter int unsigned N = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_f;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_f;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;

  logic [2:0]   alu_f;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_y;
  logic         alu_cout;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_y;
  logic         rsp_cout;
  logic         rsp_err;

`ifdef ALU_SHARE_STATS_EN
  logic [15:0]  stat_grant0;
  logic [15:0]  stat_grant1;

  modport slave (
    input  req0_valid, req0_f, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_f, req1_a, req1_b,
    output req1_ready,
    output alu_f, alu_a, alu_b,
    input  alu_y, alu_cout,
    output rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_err,
    input  rsp_ready,
    output stat_grant0, stat_grant1
  );

  modport master (
    output req0_valid, req0_f, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_f, req1_a, req1_b,
    input  req1_ready,
    input  alu_f, alu_a, alu_b,
    output alu_y, alu_cout,
    input  rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_err,
    output rsp_ready,
    input  stat_grant0, stat_grant1
  );
`else
  modport slave (
    input  req0_valid, req0_f, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_f, req1_a, req1_b,
    output req1_ready,
    output alu_f, alu_a, alu_b,
    input  alu_y, alu_cout,
    output rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_f, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_f, req1_a, req1_b,
    input  req1_ready,
    input  alu_f, alu_a, alu_b,
    output alu_y, alu_cout,
    input  rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_err,
    output rsp_ready
  );
`endif
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational Alu between two requesters.
// Define ALU_SHARE_STATS_EN to add saturating per-requester grant counters.
module alu_share_ctrl #(
  parameter int unsigned N = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_share_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         id_q, id_d;
  logic [2:0]   alu_f_q, alu_f_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_y_q, rsp_y_d;
  logic         rsp_cout_q, rsp_cout_d;
  logic         rsp_err_q, rsp_err_d;

  logic grant0, grant1, idle;

  // On contention the requester that did not win last time is served.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
  assign idle   = (state_q == StIdle);

  assign bus.req0_ready = rst_n & idle & grant0;
  assign bus.req1_ready = rst_n & idle & grant1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    alu_f_d      = alu_f_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          id_d         = grant1;
          last_grant_d = grant1;
          alu_f_d      = grant1 ? bus.req1_f : bus.req0_f;
          alu_a_d      = grant1 ? bus.req1_a : bus.req0_a;
          alu_b_d      = grant1 ? bus.req1_b : bus.req0_b;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        if (alu_f_q == 3'd3) begin
          rsp_err_d  = 1'b1;
          rsp_y_d    = '0;
          rsp_cout_d = 1'b0;
        end else begin
          rsp_err_d  = 1'b0;
          rsp_y_d    = bus.alu_y;
          rsp_cout_d = bus.alu_cout;
        end
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_f_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      alu_f_q      <= alu_f_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.alu_f     = alu_f_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef ALU_SHARE_STATS_EN
  logic [15:0] stat0_q, stat1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (bus.req0_ready && (stat0_q != 16'hFFFF)) stat0_q <= stat0_q + 16'd1;
      if (bus.req1_ready && (stat1_q != 16'hFFFF)) stat1_q <= stat1_q + 16'd1;
    end
  end

  assign bus.stat_grant0 = stat0_q;
  assign bus.stat_grant1 = stat1_q;
`else
  // Statistics build option disabled: no counters.
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural Alu model on the alu_* bus.
// Covers the stat_grant counters when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_ctrl;
  localparam int unsigned N = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_share_ctrl_if #(.N(N)) bus ();

  alu_share_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Alu model: 0 AND, 1 OR, 2 ADD, 4 AND~b, 5 OR~b, 6 SUB, 7 SLT; 3 yields junk.
  logic [N:0] alu_res;
  logic [N:0] diff;
  always_comb begin
    diff = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
    case (bus.alu_f)
      3'd0:    alu_res = {1'b0, bus.alu_a & bus.alu_b};
      3'd1:    alu_res = {1'b0, bus.alu_a | bus.alu_b};
      3'd2:    alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd4:    alu_res = {1'b0, bus.alu_a & ~bus.alu_b};
      3'd5:    alu_res = {1'b0, bus.alu_a | ~bus.alu_b};
      3'd6:    alu_res = diff;
      3'd7:    alu_res = {diff[N], {(N-1){1'b0}}, diff[N-1]};
      default: alu_res = {1'b1, bus.alu_a + bus.alu_b};
    endcase
  end
  assign bus.alu_y    = alu_res[N-1:0];
  assign bus.alu_cout = alu_res[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_rsp(input string tag, input logic id, input logic [N-1:0] y,
                         input logic cout, input logic err);
    chk({tag, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, ".id"},    {31'd0, bus.rsp_id},    {31'd0, id});
    chk({tag, ".y"},     {24'd0, bus.rsp_y},     {24'd0, y});
    chk({tag, ".cout"},  {31'd0, bus.rsp_cout},  {31'd0, cout});
    chk({tag, ".err"},   {31'd0, bus.rsp_err},   {31'd0, err});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_f = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_f = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;

    // Reset: ready must stay low even with a valid request.
    next_cycle();
    next_cycle();
    bus.req0_valid = 1'b1;
    sample();
    chk("rst.ready0",    {31'd0, bus.req0_ready}, 32'd0);
    chk("rst.rsp_valid", {31'd0, bus.rsp_valid},  32'd0);
    chk("rst.alu_f",     {29'd0, bus.alu_f},      32'd0);
    chk("rst.rsp_y",     {24'd0, bus.rsp_y},      32'd0);

    // Single op: ADD 2+3.
    next_cycle();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_f = 3'd2; bus.req0_a = 8'd2; bus.req0_b = 8'd3;
    sample();
    chk("single.ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("single.ready1", {31'd0, bus.req1_ready}, 32'd0);
    next_cycle();
    bus.req0_valid = 1'b0;
    sample();
    chk("single.alu_f",     {29'd0, bus.alu_f},      32'd2);
    chk("single.alu_a",     {24'd0, bus.alu_a},      32'd2);
    chk("single.alu_b",     {24'd0, bus.alu_b},      32'd3);
    chk("single.rsp_early", {31'd0, bus.rsp_valid},  32'd0);
    next_cycle();
    bus.rsp_ready = 1'b1;
    sample();
    chk_rsp("single", 1'b0, 8'd5, 1'b0, 1'b0);
    next_cycle();
    bus.rsp_ready = 1'b0;
    sample();
    chk("single.clear", {31'd0, bus.rsp_valid}, 32'd0);

    // Both valid and held after a fresh reset: grants 0,1,0.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_f = 3'd6; bus.req0_a = 8'd2; bus.req0_b = 8'd3;
    bus.req1_valid = 1'b1; bus.req1_f = 3'd7; bus.req1_a = 8'd2; bus.req1_b = 8'd3;
    bus.rsp_ready  = 1'b1;
    sample();
    chk("rr.g0.ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("rr.g0.ready1", {31'd0, bus.req1_ready}, 32'd0);
    next_cycle();
    sample();
    chk("rr.exec.ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rr.exec.ready1", {31'd0, bus.req1_ready}, 32'd0);
    next_cycle();
    sample();
    chk_rsp("rr.r0", 1'b0, 8'hFF, 1'b0, 1'b0);
    next_cycle();
    sample();
    chk("rr.g1.rsp_valid", {31'd0, bus.rsp_valid},  32'd0);
    chk("rr.g1.ready1",    {31'd0, bus.req1_ready}, 32'd1);
    chk("rr.g1.ready0",    {31'd0, bus.req0_ready}, 32'd0);
    next_cycle();
    next_cycle();
    sample();
    chk_rsp("rr.r1", 1'b1, 8'd1, 1'b0, 1'b0);
    next_cycle();
    sample();
    chk("rr.g2.ready0", {31'd0, bus.req0_ready}, 32'd1);
    next_cycle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    next_cycle();
    sample();
    chk_rsp("rr.r2", 1'b0, 8'hFF, 1'b0, 1'b0);
    next_cycle();
    bus.rsp_ready = 1'b0;

    // Backpressure: OR 2|3 from req1, response held for 5 cycles.
    bus.req1_valid = 1'b1; bus.req1_f = 3'd1; bus.req1_a = 8'd2; bus.req1_b = 8'd3;
    sample();
    chk("bp.ready1", {31'd0, bus.req1_ready}, 32'd1);
    next_cycle();
    bus.req0_valid = 1'b1; bus.req0_f = 3'd2;
    sample();
    chk("bp.exec.ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("bp.exec.ready1", {31'd0, bus.req1_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      sample();
      chk("bp.hold.valid",  {31'd0, bus.rsp_valid},  32'd1);
      chk("bp.hold.y",      {24'd0, bus.rsp_y},      32'd3);
      chk("bp.hold.id",     {31'd0, bus.rsp_id},     32'd1);
      chk("bp.hold.ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("bp.hold.ready1", {31'd0, bus.req1_ready}, 32'd0);
    end
    next_cycle();
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    sample();
    chk("bp.ack.valid", {31'd0, bus.rsp_valid}, 32'd1);
    next_cycle();
    bus.rsp_ready = 1'b0;
    sample();
    chk("bp.clear", {31'd0, bus.rsp_valid}, 32'd0);

    // Unsupported F=3 from req0.
    next_cycle();
    bus.req0_valid = 1'b1; bus.req0_f = 3'd3; bus.req0_a = 8'd2; bus.req0_b = 8'd3;
    sample();
    chk("err.ready0", {31'd0, bus.req0_ready}, 32'd1);
    next_cycle();
    bus.req0_valid = 1'b0;
    next_cycle();
    bus.rsp_ready = 1'b1;
    sample();
    chk_rsp("err", 1'b0, 8'd0, 1'b0, 1'b1);
    next_cycle();
    bus.rsp_ready = 1'b0;
    sample();
    chk("err.clear", {31'd0, bus.rsp_valid}, 32'd0);

    // Reset while in EXEC drops the op.
    next_cycle();
    bus.req0_valid = 1'b1; bus.req0_f = 3'd2; bus.req0_a = 8'hFF; bus.req0_b = 8'd1;
    sample();
    chk("rexec.ready0", {31'd0, bus.req0_ready}, 32'd1);
    next_cycle();
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_f = 3'd0; bus.req1_a = 8'd2; bus.req1_b = 8'd3;
    sample();
    chk("rexec.rst.ready1", {31'd0, bus.req1_ready}, 32'd0);
    next_cycle();
    sample();
    chk("rexec.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rexec.alu_f",     {29'd0, bus.alu_f},     32'd0);
    chk("rexec.alu_a",     {24'd0, bus.alu_a},     32'd0);
    chk("rexec.alu_b",     {24'd0, bus.alu_b},     32'd0);
    chk("rexec.rsp_y",     {24'd0, bus.rsp_y},     32'd0);
    chk("rexec.rsp_misc",  {29'd0, bus.rsp_id, bus.rsp_cout, bus.rsp_err}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    sample();
    chk("rexec.new.ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("rexec.new.noval",  {31'd0, bus.rsp_valid},  32'd0);
    next_cycle();
    bus.req1_valid = 1'b0;
    sample();
    chk("rexec.exec.noval", {31'd0, bus.rsp_valid}, 32'd0);
    next_cycle();
    bus.rsp_ready = 1'b1;
    sample();
    chk_rsp("rexec.new", 1'b1, 8'd2, 1'b0, 1'b0);
    next_cycle();
    bus.rsp_ready = 1'b0;

`ifdef ALU_SHARE_STATS_EN
    // Five alternating grants from reset: 0,1,0,1,0.
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_f = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_f = 3'd1;
    bus.rsp_ready  = 1'b1;
    sample();
    chk("stat.rst0", {16'd0, bus.stat_grant0}, 32'd0);
    chk("stat.rst1", {16'd0, bus.stat_grant1}, 32'd0);
    for (int k = 0; k < 12; k++) next_cycle();
    next_cycle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    next_cycle();
    sample();
    chk("stat.grant0", {16'd0, bus.stat_grant0}, 32'd3);
    chk("stat.grant1", {16'd0, bus.stat_grant1}, 32'd2);
    bus.rsp_ready = 1'b0;
`else
    next_cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
